// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back arbiter with destination scoreboard
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         per-requester write-back handshake (0 ALU, 1 LSU, 2 MDU)
//   req_rd/req_data             packed per-requester destination and data, requester i in slice i
//   rf_we/rf_rd_addr/rf_wd      registered register-file write port, one cycle after acceptance
//   iss_valid/iss_rd/iss_ready  issue-time destination reservation, blocked on WAW
//   rs1_addr/rs2_addr/stall     RAW hazard detection for the instruction in decode
//   rs1_byp/rs2_byp/byp_data    forwarding of the write in flight, only with WB_BYPASS_EN defined
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic [XLEN*NREQ-1:0] req_data,
  output logic                 rf_we,
  output logic [4:0]           rf_rd_addr,
  output logic [XLEN-1:0]      rf_wd,
  input  logic                 iss_valid,
  input  logic [4:0]           iss_rd,
  output logic                 iss_ready,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  output logic                 stall
`ifdef WB_BYPASS_EN
  ,
  output logic                 rs1_byp,
  output logic                 rs2_byp,
  output logic [XLEN-1:0]      byp_data
`endif
);
  localparam int LGW = $clog2(NREQ);
  logic [31:0]     pending_q, pending_d;
  logic [LGW-1:0]  last_grant_q, last_grant_d, idx;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_addr_q, rf_rd_addr_d, sel_rd;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d, sel_data;
  logic [NREQ-1:0] gnt;
  logic            hs, haz1, haz2;
  // First valid requester at or after last_grant+1 wins; grants are suppressed during reset.
  always_comb begin
    gnt = '0;
    idx = '0;
    last_grant_d = last_grant_q;
    sel_rd = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = LGW'((int'(last_grant_q) + 1 + k) % NREQ);
      if (gnt == '0 && req_valid[idx] && rst_n) begin
        gnt[idx] = 1'b1;
        last_grant_d = idx;
        sel_rd = req_rd[5*idx +: 5];
        sel_data = req_data[XLEN*idx +: XLEN];
      end
    end
  end
  assign req_ready = gnt;
  assign hs = |gnt;
  assign iss_ready = rst_n && (iss_rd == 5'd0 || !pending_q[iss_rd]);
  // Set is applied after the clear so a same-edge issue keeps the register reserved.
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) pending_d[rf_rd_addr_q] = 1'b0;
    if (iss_valid && iss_ready && iss_rd != 5'd0) pending_d[iss_rd] = 1'b1;
    pending_d[0] = 1'b0;
    rf_we_d = hs && sel_rd != 5'd0;
    rf_rd_addr_d = hs ? sel_rd : rf_rd_addr_q;
    rf_wd_d = hs ? sel_data : rf_wd_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      last_grant_q <= LGW'(NREQ - 1);
      rf_we_q <= 1'b0;
      rf_rd_addr_q <= '0;
      rf_wd_q <= '0;
    end else begin
      pending_q <= pending_d;
      last_grant_q <= last_grant_d;
      rf_we_q <= rf_we_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      rf_wd_q <= rf_wd_d;
    end
  end
  assign rf_we = rf_we_q;
  assign rf_rd_addr = rf_rd_addr_q;
  assign rf_wd = rf_wd_q;
  assign haz1 = rs1_addr != 5'd0 && pending_q[rs1_addr];
  assign haz2 = rs2_addr != 5'd0 && pending_q[rs2_addr];
`ifdef WB_BYPASS_EN
  // An operand being written this cycle is forwarded instead of stalling.
  assign rs1_byp = rf_we_q && rs1_addr == rf_rd_addr_q && rs1_addr != 5'd0;
  assign rs2_byp = rf_we_q && rs2_addr == rf_rd_addr_q && rs2_addr != 5'd0;
  assign byp_data = rf_wd_q;
  assign stall = (haz1 && !rs1_byp) || (haz2 && !rs2_byp);
`else
  assign stall = haz1 || haz2;
`endif
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of write-back and register-file write data.
REQ-002 SHALL have parameter NREQ, fixed at 3, number of write-back requesters (0 ALU, 1 LSU, 2 MDU).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req_valid, req_ready  input/output  NREQ  per-requester write-back handshake.
REQ-006 SHALL have ports req_rd, req_data  input  5*NREQ, XLEN*NREQ  destination and data; requester i in slice i.
REQ-007 SHALL have ports rf_we, rf_rd_addr, rf_wd  output  1, 5, XLEN  registered register-file write port.
REQ-008 SHALL have ports iss_valid, iss_rd, iss_ready  input, input, output  1, 5, 1  issue-time destination reservation.
REQ-009 SHALL have ports rs1_addr, rs2_addr  input  5 each  source operands of the instruction in decode.
REQ-010 SHALL have port stall  output  1  RAW hazard on rs1/rs2.

Function
REQ-011 SHALL keep a 32-bit pending vector; bit 0 permanently 0.
REQ-012 SHALL set pending[iss_rd] on an edge where iss_valid and iss_ready are high and iss_rd != 0; iss_rd == 0 sets nothing.
REQ-013 SHALL drive iss_ready = !pending[iss_rd] combinationally (WAW stall); iss_ready = 1 when iss_rd == 0.
REQ-014 SHALL grant at most one requester per cycle, round-robin: search starts at (last_grant+1) mod 3; req_ready[i] high only for the granted requester with req_valid[i] high.
REQ-015 SHALL update last_grant only on an accepted handshake (req_valid & req_ready).
REQ-016 SHALL register the accepted request: next cycle rf_we = 1 if req_rd != 0, else 0; rf_rd_addr/rf_wd = accepted rd/data; one-cycle latency.
REQ-017 SHALL drive rf_we = 0 in cycles following no handshake; rf_rd_addr/rf_wd hold their last values.
REQ-018 SHALL clear pending[rf_rd_addr] on the edge where rf_we is high (the same edge the register file captures).
REQ-019 SHALL give set priority when an issue and a clear target the same register on the same edge.
REQ-020 SHALL drive stall = (rs1_addr != 0 & pending[rs1_addr]) | (rs2_addr != 0 & pending[rs2_addr]).
REQ-021 SHALL accept requests whose rd is not pending; the register write proceeds and no pending bit changes except per REQ-018.
REQ-022 SHALL sustain one write-back per cycle with back-to-back handshakes and no bubble.

Reset
REQ-023 SHALL, on rst_n low, asynchronously clear pending, rf_we, rf_rd_addr, rf_wd, and set last_grant = 2, making requester 0 first priority.
REQ-024 SHALL drive req_ready = 0 and iss_ready = 0 while rst_n is low; a transfer in flight at reset assertion is dropped.

Configuration
REQ-025 SHALL support macro WB_BYPASS_EN, enabling forwarding outputs rs1_byp, rs2_byp (1 bit) and byp_data (XLEN).
REQ-026 SHALL, with WB_BYPASS_EN defined: rsN_byp = rf_we & rsN_addr == rf_rd_addr & rsN_addr != 0; byp_data = rf_wd; a bypassed operand does not contribute to stall.
REQ-027 SHALL, without WB_BYPASS_EN: bypass ports absent; stall per REQ-020 only.

Verification
REQ-028 SHALL cover: reset, then all three req_valid high for 3 cycles, rd 5/6/7 -> grants 0,1,2 in order; rf_we one cycle after each grant.
REQ-029 SHALL cover: issue rd=3; rs1_addr=3 -> stall=1 until the edge rf_we writes x3 with 0xDEADBEEF, then stall=0 (with WB_BYPASS_EN: stall=0 and rs1_byp=1, byp_data=0xDEADBEEF in the rf_we cycle).
REQ-030 SHALL cover: issue rd=4 while pending[4] set -> iss_ready=0; after clear -> iss_ready=1 and pending[4] set again.
REQ-031 SHALL cover: same-edge issue rd=9 and rf_we clear of x9 -> pending[9]=1 afterwards.
REQ-032 SHALL cover: write-back with rd=0 -> handshake completes, rf_we=0; issue rd=0 -> no pending change, stall=0 for rs1_addr=0.
REQ-033 SHALL cover: rst_n low mid-stream with pending bits set -> all outputs zero immediately; first grant after release to requester 0.
